// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and round-robin search helper for the FIFO write arbiter
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    localparam int BEAT_CNT_W = 16;
    localparam int MAX_REQ    = 16;
    localparam int REQ_IDX_W  = 4;

    typedef struct packed {
        logic                 found;
        logic [REQ_IDX_W-1:0] idx;
    } rr_result_t;

    // Walks from the farthest candidate back to last+1 so the nearest requester is written last and wins.
    function automatic rr_result_t rr_next(input logic [MAX_REQ-1:0] req,
                                           input logic [REQ_IDX_W-1:0] last,
                                           input int n);
        rr_result_t r;
        int         idx;
        r = '0;
        for (int k = MAX_REQ; k >= 1; k--) begin
            if (k <= n) begin
                idx = (int'(last) + k) % n;
                if (req[idx[REQ_IDX_W-1:0]]) begin
                    r.found = 1'b1;
                    r.idx   = idx[REQ_IDX_W-1:0];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotate-priority encoder starting one past the last winner
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]    last,
    output logic [ID_W-1:0]    grant_id,
    output logic               grant_valid
);

    logic [MAX_REQ-1:0] req_ext;
    rr_result_t         pick;

    always_comb begin
        req_ext              = '0;
        req_ext[NUM_REQ-1:0] = req_valid;
        pick                 = rr_next(req_ext, REQ_IDX_W'(last), NUM_REQ);
    end

    assign grant_id    = ID_W'(pick.idx);
    assign grant_valid = pick.found;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin arbiter sharing one FIFO write port among NUM_REQ producers
// Burst locking of a winner for up to MAX_BURST beats is built when FIFO_ARB_BURST_EN is defined.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4,
    localparam int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data,
    input  logic                          fifo_full,
    output logic [ID_W-1:0]               grant_id,
    output logic                          grant_valid,
    output logic [BEAT_CNT_W-1:0]         beat_count
);

    if (NUM_REQ < 2 || NUM_REQ > MAX_REQ || MAX_BURST < 1 || MAX_BURST > 255) begin : g_param_check
        $error("fifo_wr_arbiter: NUM_REQ or MAX_BURST out of range");
    end

    logic [ID_W-1:0]       last_grant;
    logic [ID_W-1:0]       rr_id;
    logic                  rr_valid;
    logic                  fire;
    logic [BEAT_CNT_W-1:0] beat_q;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .req_valid   (req_valid),
        .last        (last_grant),
        .grant_id    (rr_id),
        .grant_valid (rr_valid)
    );

`ifdef FIFO_ARB_BURST_EN
    arb_state_t state;
    logic [ID_W-1:0] lock_id;
    logic [7:0]      burst_cnt;
    logic [7:0]      burst_nxt;

    assign burst_nxt = burst_cnt + 8'd1;

    // A locked producer that drops valid leaves the port idle for that cycle rather than re-arbitrating.
    always_comb begin
        if (state == LOCK) begin
            grant_id    = lock_id;
            grant_valid = req_valid[lock_id];
        end else begin
            grant_id    = rr_id;
            grant_valid = rr_valid;
        end
    end
`else
    assign grant_id    = rr_id;
    assign grant_valid = rr_valid;
`endif

    always_comb begin
        req_ready = '0;
        if (grant_valid && !fifo_full) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    assign fifo_wr_en   = |(req_valid & req_ready);
    assign fire         = fifo_wr_en;
    assign fifo_wr_data = grant_valid ? req_data[grant_id*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign beat_count   = beat_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= ID_W'(NUM_REQ - 1);
            beat_q     <= '0;
`ifdef FIFO_ARB_BURST_EN
            state      <= ARB;
            lock_id    <= '0;
            burst_cnt  <= '0;
`endif
        end else begin
            if (fire) begin
                beat_q <= beat_q + BEAT_CNT_W'(1);
            end
`ifdef FIFO_ARB_BURST_EN
            if (state == ARB) begin
                if (fire) begin
                    last_grant <= grant_id;
                    if (MAX_BURST > 1) begin
                        state     <= LOCK;
                        lock_id   <= grant_id;
                        burst_cnt <= 8'd1;
                    end
                end
            end else begin
                if (fire) begin
                    burst_cnt <= burst_nxt;
                    if (burst_nxt == 8'(MAX_BURST)) begin
                        state      <= ARB;
                        last_grant <= lock_id;
                    end
                end else if (!req_valid[lock_id] && !fifo_full) begin
                    state <= ARB;
                end
            end
`else
            if (fire) begin
                last_grant <= grant_id;
            end
`endif
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - table-driven and directed checks of fifo_wr_arbiter against a 16-deep FIFO model
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        fifo_wr_en;
    logic [7:0]  fifo_wr_data;
    logic        fifo_full;
    logic [1:0]  grant_id;
    logic        grant_valid;
    logic [15:0] beat_count;

    logic        force_full;
    logic        model_full;
    logic        fifo_rd;
    logic [7:0]  fifo_q[$];
    logic [7:0]  wr_log[$];

    int errors = 0;
    int checks = 0;

    assign fifo_full = model_full | force_full;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .NUM_REQ    (4),
        .DATA_WIDTH (8),
        .MAX_BURST  (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .fifo_full    (fifo_full),
        .grant_id     (grant_id),
        .grant_valid  (grant_valid),
        .beat_count   (beat_count)
    );

    always @(posedge clk) begin
        if (rst) begin
            fifo_q.delete();
            model_full <= 1'b0;
        end else begin
            if (fifo_rd && fifo_q.size() > 0) void'(fifo_q.pop_front());
            if (fifo_wr_en) begin
                fifo_q.push_back(fifo_wr_data);
                wr_log.push_back(fifo_wr_data);
            end
            model_full <= (fifo_q.size() == 16);
        end
    end

    typedef struct {
        logic [3:0] valid;
        logic       full;
        logic [3:0] ready;
        logic       gvalid;
        logic [1:0] gid;
        logic       wr_en;
        logic [7:0] data;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = 4'h0;
        repeat (2) cyc();
        rst = 1'b0;
        wr_log.delete();
    endtask

    task automatic check_log(input string name, input int idx, input logic [7:0] exp);
        if (wr_log.size() > idx) check(name, 32'(wr_log[idx]), 32'(exp));
        else check(name, 32'hDEAD, 32'(exp));
    endtask

    initial begin
        vec_t vecs[14];
        logic bad;

        rst        = 1'b1;
        req_valid  = 4'hF;
        req_data   = 32'hA3A2_A1A0;
        force_full = 1'b0;
        fifo_rd    = 1'b0;

        // Reset held with every producer valid
        repeat (5) cyc();
        check("reset beat_count", 32'(beat_count), 32'd0);
        check("reset grant_valid", 32'(grant_valid), 32'd1);
        check("reset grant_id", 32'(grant_id), 32'd0);
        rst = 1'b0;
        wr_log.delete();
        #1;
        check("post-reset beat_count", 32'(beat_count), 32'd0);
        cyc();
        check_log("first fire producer", 0, 8'hA0);
        check("first fire beat_count", 32'(beat_count), 32'd1);

        // Full stall with a real FIFO model
        do_reset();
        req_data  = 32'h005C_0077;
        req_valid = 4'b0001;
        repeat (16) cyc();
        req_valid = 4'b0100;
        check("stall fifo_full", 32'(fifo_full), 32'd1);
        check("stall fill beat_count", 32'(beat_count), 32'd16);
        bad = 1'b0;
        repeat (3) begin
            #1;
            if (fifo_wr_en || req_ready != 4'h0) bad = 1'b1;
            cyc();
        end
        fifo_rd = 1'b1;
        #1;
        if (fifo_wr_en || req_ready != 4'h0) bad = 1'b1;
        check("stall no accept while full", 32'(bad), 32'd0);
        cyc();
        fifo_rd = 1'b0;
        #1;
        check("stall release wr_en", 32'(fifo_wr_en), 32'd1);
        check("stall release ready", 32'(req_ready), 32'h4);
        check("stall release data", 32'(fifo_wr_data), 32'h5C);
        check("stall release beat_count before", 32'(beat_count), 32'd16);
        cyc();
        req_valid = 4'h0;
        check("stall beat_count after", 32'(beat_count), 32'd17);
        check_log("stall last write", 16, 8'h5C);

`ifndef FIFO_ARB_BURST_EN
        // Round-robin over all four producers
        do_reset();
        req_data  = 32'hA3A2_A1A0;
        req_valid = 4'hF;
        repeat (8) cyc();
        req_valid = 4'h0;
        check("rr write count", 32'(wr_log.size()), 32'd8);
        for (int i = 0; i < 8; i++) check_log($sformatf("rr write %0d", i), i, 8'hA0 + 8'(i % 4));
        check("rr beat_count", 32'(beat_count), 32'd8);

        // Sparse producers 1 and 3
        do_reset();
        req_data  = 32'h3300_1100;
        req_valid = 4'b1010;
        bad = 1'b0;
        repeat (4) begin
            #1;
            if (req_ready[0] || req_ready[2]) bad = 1'b1;
            cyc();
        end
        req_valid = 4'h0;
        check("sparse ready0/2 low", 32'(bad), 32'd0);
        check_log("sparse write 0", 0, 8'h11);
        check_log("sparse write 1", 1, 8'h33);
        check_log("sparse write 2", 2, 8'h11);
        check_log("sparse write 3", 3, 8'h33);

        // Vector table, starting from last_grant = 3
        vecs[0]  = '{4'hF, 1'b0, 4'h1, 1'b1, 2'd0, 1'b1, 8'hA0};
        vecs[1]  = '{4'hF, 1'b0, 4'h2, 1'b1, 2'd1, 1'b1, 8'hA1};
        vecs[2]  = '{4'hF, 1'b1, 4'h0, 1'b1, 2'd2, 1'b0, 8'hA2};
        vecs[3]  = '{4'hF, 1'b0, 4'h4, 1'b1, 2'd2, 1'b1, 8'hA2};
        vecs[4]  = '{4'h0, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0, 8'h00};
        vecs[5]  = '{4'hA, 1'b0, 4'h8, 1'b1, 2'd3, 1'b1, 8'hA3};
        vecs[6]  = '{4'hA, 1'b0, 4'h2, 1'b1, 2'd1, 1'b1, 8'hA1};
        vecs[7]  = '{4'hA, 1'b0, 4'h8, 1'b1, 2'd3, 1'b1, 8'hA3};
        vecs[8]  = '{4'h1, 1'b0, 4'h1, 1'b1, 2'd0, 1'b1, 8'hA0};
        vecs[9]  = '{4'h1, 1'b0, 4'h1, 1'b1, 2'd0, 1'b1, 8'hA0};
        vecs[10] = '{4'h9, 1'b0, 4'h8, 1'b1, 2'd3, 1'b1, 8'hA3};
        vecs[11] = '{4'h9, 1'b1, 4'h0, 1'b1, 2'd0, 1'b0, 8'hA0};
        vecs[12] = '{4'h8, 1'b1, 4'h0, 1'b1, 2'd3, 1'b0, 8'hA3};
        vecs[13] = '{4'h9, 1'b0, 4'h1, 1'b1, 2'd0, 1'b1, 8'hA0};
        do_reset();
        req_data = 32'hA3A2_A1A0;
        for (int i = 0; i < 14; i++) begin
            req_valid  = vecs[i].valid;
            force_full = vecs[i].full;
            #1;
            check($sformatf("vec %0d req_ready", i), 32'(req_ready), 32'(vecs[i].ready));
            check($sformatf("vec %0d grant_valid", i), 32'(grant_valid), 32'(vecs[i].gvalid));
            if (vecs[i].gvalid) check($sformatf("vec %0d grant_id", i), 32'(grant_id), 32'(vecs[i].gid));
            check($sformatf("vec %0d wr_en", i), 32'(fifo_wr_en), 32'(vecs[i].wr_en));
            check($sformatf("vec %0d wr_data", i), 32'(fifo_wr_data), 32'(vecs[i].data));
            cyc();
        end
        req_valid  = 4'h0;
        force_full = 1'b0;
        check("vec beat_count", 32'(beat_count), 32'd10);
`else
        // Burst lock of four beats per producer
        do_reset();
        req_data  = 32'hA3A2_A1A0;
        req_valid = 4'b0011;
        repeat (8) cyc();
        req_valid = 4'h0;
        for (int i = 0; i < 8; i++) check_log($sformatf("burst write %0d", i), i, (i < 4) ? 8'hA0 : 8'hA1);

        // Locked producer drops valid after two beats
        do_reset();
        req_valid = 4'b0011;
        repeat (2) cyc();
        req_valid = 4'b0010;
        #1;
        check("drop idle grant_valid", 32'(grant_valid), 32'd0);
        check("drop idle wr_en", 32'(fifo_wr_en), 32'd0);
        cyc();
        check("drop next grant_valid", 32'(grant_valid), 32'd1);
        check("drop next grant_id", 32'(grant_id), 32'd1);
        check("drop next wr_en", 32'(fifo_wr_en), 32'd1);
        cyc();
        req_valid = 4'h0;

        // Reset during beat two of a lock
        do_reset();
        req_valid = 4'b0011;
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        wr_log.delete();
        req_valid = 4'b0010;
        #1;
        check("midreset unlocked grant_valid", 32'(grant_valid), 32'd1);
        check("midreset unlocked grant_id", 32'(grant_id), 32'd1);
        req_valid = 4'b0011;
        #1;
        check("midreset priority grant_id", 32'(grant_id), 32'd0);
        cyc();
        req_valid = 4'h0;
        check_log("midreset first write", 0, 8'hA0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
